// File: rtl/lock_sequencer.sv
// ---------------------------------------------------------------------------
// lock_sequencer
//
// Keypad-driven sequencer for the combination lock. It takes one 4-bit key
// code per `valid` strobe, collects password digits and runs these flows:
// enter/compare, change-password and lockout. It also holds the stored
// password register.
//
// Key codes: 0-9 are digits, 4'hA is '*', 4'hB is '#', 4'hC-4'hF are ignored.
//
// Parameters
//   CODE_LEN       digits per password (1..8)
//   MAX_TRIES      consecutive failed compares before lockout (1..7)
//   OPEN_CYCLES    cycles `open` is held after a match
//   LOCKOUT_CYCLES cycles `lock` is held
//   DEFAULT_PW     password after reset, first digit in the MS nibble
//   IDLE_TIMEOUT   inactivity limit in cycles (used only with LOCK_TIMEOUT_EN)
//
// Ports
//   clk         in   system clock
//   reset_1     in   synchronous active-high reset
//   code[3:0]   in   key code, qualified by valid
//   valid       in   one-cycle strobe, one code consumed per high cycle
//   open        out  lock released (state OPEN, one cycle behind the state)
//   lock        out  lockout active (state LOCKOUT, one cycle behind)
//   save_light  out  change-password flow active (SAV_* states, one cycle behind)
//   err         out  one-cycle pulse on a failed, aborted or timed-out entry
//   tries[2:0]  out  current consecutive-failure count
//
// Build option
//   LOCK_TIMEOUT_EN  when this is defined, a partial entry in ENTER/SAV_* is
//                    abandoned with an `err` pulse after IDLE_TIMEOUT cycles
//                    without `valid`.
// ---------------------------------------------------------------------------
module lock_sequencer #(
   parameter int                    CODE_LEN       = 4,
   parameter int                    MAX_TRIES      = 3,
   parameter int                    OPEN_CYCLES    = 500,
   parameter int                    LOCKOUT_CYCLES = 1000,
   parameter logic [4*CODE_LEN-1:0] DEFAULT_PW     = 16'h1234,
   parameter int                    IDLE_TIMEOUT   = 2000
) (
   input  logic       clk,
   input  logic       reset_1,
   input  logic [3:0] code,
   input  logic       valid,
   output logic       open,
   output logic       lock,
   output logic       save_light,
   output logic       err,
   output logic [2:0] tries
);

   localparam int BUF_W  = 4 * CODE_LEN;
   localparam int CNT_W  = $clog2(CODE_LEN + 1);
   localparam int OPEN_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
   localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CODE_LEN);
   localparam logic [OPEN_W-1:0] OPEN_LOAD = OPEN_W'(OPEN_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]        TRY_MAX   = 3'(MAX_TRIES);

   // Stop elaboration if a parameter is outside the range the logic supports.
   if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_TRIES < 1 || MAX_TRIES > 7 ||
       OPEN_CYCLES < 2 || LOCKOUT_CYCLES < 2 || IDLE_TIMEOUT < 2) begin : g_param_check
      $error("lock_sequencer: parameter out of supported range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTER,
      S_CHECK,
      S_OPEN,
      S_SAV_OLD,
      S_SAV_NEW,
      S_SAV_CONF,
      S_LOCKOUT
   } state_t;

   state_t             state_reg,    state_next;
   logic [BUF_W-1:0]   buf_reg,      buf_next;
   logic [CNT_W-1:0]   cnt_reg,      cnt_next;
   logic               ovf_reg,      ovf_next;
   logic [BUF_W-1:0]   pw_reg,       pw_next;
   logic [BUF_W-1:0]   new_pw_reg,   new_pw_next;
   logic [2:0]         tries_reg,    tries_next;
   logic [OPEN_W-1:0]  open_tmr_reg, open_tmr_next;
   logic [LOCK_W-1:0]  lock_tmr_reg, lock_tmr_next;
   logic               err_next;

   logic               open_reg;
   logic               lock_reg;
   logic               save_reg;
   logic               err_reg;

`ifdef LOCK_TIMEOUT_EN
   localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TIMEOUT - 1);
   logic [IDLE_W-1:0]  idle_tmr_reg, idle_tmr_next;
`endif

   // Key decode
   logic key_digit, key_star, key_hash;
   assign key_digit = valid && (code <= 4'd9);
   assign key_star  = valid && (code == 4'hA);
   assign key_hash  = valid && (code == 4'hB);

   // An entry has the right length only when exactly CODE_LEN digits arrived.
   logic entry_full, pw_match, new_match;
   assign entry_full = (cnt_reg == CNT_FULL) && !ovf_reg;
   assign pw_match   = entry_full && (buf_reg == pw_reg);
   assign new_match  = entry_full && (buf_reg == new_pw_reg);

   logic [2:0] tries_inc;
   assign tries_inc = tries_reg + 3'd1;

   // Action flags that the state decode sets. They are applied after the case
   // so the buffer and try handling is written once.
   logic shift_digit, clear_buf, try_failed;

   always_comb begin
      state_next    = state_reg;
      buf_next      = buf_reg;
      cnt_next      = cnt_reg;
      ovf_next      = ovf_reg;
      pw_next       = pw_reg;
      new_pw_next   = new_pw_reg;
      tries_next    = tries_reg;
      open_tmr_next = open_tmr_reg;
      lock_tmr_next = lock_tmr_reg;
      err_next      = 1'b0;
      shift_digit   = 1'b0;
      clear_buf     = 1'b0;
      try_failed    = 1'b0;
`ifdef LOCK_TIMEOUT_EN
      idle_tmr_next = IDLE_LOAD;
`endif

      case (state_reg)
         S_IDLE: begin
            if (key_digit) begin
               // The first digit starts a fresh entry directly.
               buf_next   = BUF_W'(code);
               cnt_next   = CNT_W'(1);
               ovf_next   = 1'b0;
               state_next = S_ENTER;
            end else if (key_star) begin
               clear_buf  = 1'b1;
               state_next = S_SAV_OLD;
            end
         end

         S_ENTER: begin
            if (key_digit) begin
               shift_digit = 1'b1;
            end else if (key_hash) begin
               state_next = S_CHECK;
            end else if (key_star) begin
               clear_buf  = 1'b1;
               state_next = S_IDLE;
            end
         end

         S_CHECK: begin
            // Any strobe in this cycle is dropped. The keypad paces its strobes.
            if (pw_match) begin
               tries_next    = 3'd0;
               open_tmr_next = OPEN_LOAD;
               state_next    = S_OPEN;
            end else begin
               try_failed = 1'b1;
            end
            clear_buf = 1'b1;
         end

         S_OPEN: begin
            if (key_hash) begin
               open_tmr_next = OPEN_LOAD;
            end else if (open_tmr_reg == '0) begin
               state_next = S_IDLE;
            end else begin
               open_tmr_next = open_tmr_reg - OPEN_W'(1);
            end
         end

         S_SAV_OLD: begin
            if (key_digit) begin
               shift_digit = 1'b1;
            end else if (key_star) begin
               clear_buf  = 1'b1;
               state_next = S_IDLE;
            end else if (key_hash) begin
               clear_buf = 1'b1;
               if (pw_match) begin
                  tries_next = 3'd0;
                  state_next = S_SAV_NEW;
               end else begin
                  try_failed = 1'b1;
               end
            end
         end

         S_SAV_NEW: begin
            if (key_digit) begin
               shift_digit = 1'b1;
            end else if (key_star) begin
               clear_buf  = 1'b1;
               state_next = S_IDLE;
            end else if (key_hash) begin
               clear_buf = 1'b1;
               if (entry_full) begin
                  new_pw_next = buf_reg;
                  state_next  = S_SAV_CONF;
               end else begin
                  err_next   = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end

         S_SAV_CONF: begin
            if (key_digit) begin
               shift_digit = 1'b1;
            end else if (key_star) begin
               clear_buf  = 1'b1;
               state_next = S_IDLE;
            end else if (key_hash) begin
               clear_buf  = 1'b1;
               state_next = S_IDLE;
               // The password is written only here, so pw is never half-updated.
               if (new_match) begin
                  pw_next = new_pw_reg;
               end else begin
                  err_next = 1'b1;
               end
            end
         end

         S_LOCKOUT: begin
            if (lock_tmr_reg == '0) begin
               tries_next = 3'd0;
               state_next = S_IDLE;
            end else begin
               lock_tmr_next = lock_tmr_reg - LOCK_W'(1);
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // A failed compare in CHECK or SAV_OLD counts toward lockout.
      if (try_failed) begin
         err_next   = 1'b1;
         tries_next = tries_inc;
         if (tries_inc >= TRY_MAX) begin
            lock_tmr_next = LOCK_LOAD;
            state_next    = S_LOCKOUT;
         end else begin
            state_next = S_IDLE;
         end
      end

`ifdef LOCK_TIMEOUT_EN
      // The inactivity counter runs only while an entry is partly collected.
      // It stays loaded in every other state, so each flow starts with the
      // full allowance.
      if (state_reg == S_ENTER || state_reg == S_SAV_OLD ||
          state_reg == S_SAV_NEW || state_reg == S_SAV_CONF) begin
         if (valid) begin
            idle_tmr_next = IDLE_LOAD;
         end else if (idle_tmr_reg == '0) begin
            err_next   = 1'b1;
            clear_buf  = 1'b1;
            state_next = S_IDLE;
         end else begin
            idle_tmr_next = idle_tmr_reg - IDLE_W'(1);
         end
      end
`endif

      // Digits after the buffer is full only mark overflow. They are not stored.
      if (shift_digit) begin
         if (cnt_reg == CNT_FULL) begin
            ovf_next = 1'b1;
         end else begin
            buf_next = BUF_W'({buf_reg, code});
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end

      if (clear_buf) begin
         buf_next = '0;
         cnt_next = '0;
         ovf_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_1) begin
         state_reg    <= S_IDLE;
         buf_reg      <= '0;
         cnt_reg      <= '0;
         ovf_reg      <= 1'b0;
         pw_reg       <= DEFAULT_PW;
         new_pw_reg   <= '0;
         tries_reg    <= 3'd0;
         open_tmr_reg <= '0;
         lock_tmr_reg <= '0;
         open_reg     <= 1'b0;
         lock_reg     <= 1'b0;
         save_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         buf_reg      <= buf_next;
         cnt_reg      <= cnt_next;
         ovf_reg      <= ovf_next;
         pw_reg       <= pw_next;
         new_pw_reg   <= new_pw_next;
         tries_reg    <= tries_next;
         open_tmr_reg <= open_tmr_next;
         lock_tmr_reg <= lock_tmr_next;
         // Indicators follow the current state, so they change one cycle
         // after the state changes. err is registered from the cycle of the
         // transition.
         open_reg     <= (state_reg == S_OPEN);
         lock_reg     <= (state_reg == S_LOCKOUT);
         save_reg     <= (state_reg == S_SAV_OLD) || (state_reg == S_SAV_NEW) ||
                         (state_reg == S_SAV_CONF);
         err_reg      <= err_next;
      end
   end

`ifdef LOCK_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset_1) begin
         idle_tmr_reg <= '0;
      end else begin
         idle_tmr_reg <= idle_tmr_next;
      end
   end
`endif

   assign open       = open_reg;
   assign lock       = lock_reg;
   assign save_light = save_reg;
   assign err        = err_reg;
   assign tries      = tries_reg;

endmodule

// File: tb/tb_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lock_sequencer
//
// Directed testbench for lock_sequencer with its default parameters
// (CODE_LEN 4, MAX_TRIES 3, OPEN 500, LOCKOUT 1000, pw 1234, IDLE_TIMEOUT 2000).
// Inputs change on the falling edge and outputs are sampled on the falling
// edge. Each key press holds `valid` high across exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_lock_sequencer;

   logic       clk = 1'b0;
   logic       reset_1 = 1'b1;
   logic [3:0] code = 4'h0;
   logic       valid = 1'b0;
   logic       open, lock, save_light, err;
   logic [2:0] tries;

   int checks = 0;
   int passes = 0;

   // Running totals of err and lock high cycles, sampled at the rising edge.
   int err_total  = 0;
   int lock_total = 0;

   lock_sequencer dut (
      .clk        (clk),
      .reset_1    (reset_1),
      .code       (code),
      .valid      (valid),
      .open       (open),
      .lock       (lock),
      .save_light (save_light),
      .err        (err),
      .tries      (tries)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (err)  err_total  <= err_total + 1;
      if (lock) lock_total <= lock_total + 1;
   end

   // One key. This task returns on the falling edge right after the sampling edge.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      code  = k;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      $display("key %h : open=%b lock=%b save=%b tries=%0d", k, open, lock, save_light, tries);
   endtask

   // Press n keys taken from the low n nibbles of keys, most significant first.
   task automatic enter(input logic [31:0] keys, input int n);
      for (int i = n - 1; i >= 0; i--) press(keys[4*i +: 4]);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_1 = 1'b1;
      valid   = 1'b0;
      repeat (3) @(negedge clk);
      reset_1 = 1'b0;
      $display("reset applied");
   endtask

   // Wait for open to drop. ok=0 if it stays high too long.
   task automatic wait_open_low(output bit ok);
      int n = 0;
      while (open && n < 2000) begin
         n++;
         @(negedge clk);
      end
      ok = !open;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (open !== 1'b0) $display("FAIL reset_open: got %b want 0", open); else passes++;
      checks++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b want 0", lock); else passes++;
      checks++; if (save_light !== 1'b0) $display("FAIL reset_save: got %b want 0", save_light); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
      checks++; if (tries !== 3'd0) $display("FAIL reset_tries: got %0d want 0", tries); else passes++;
   endtask

   task automatic test_open();
      int n = 0;
      int e0 = err_total;
      bit ok;
      enter(32'h1234B, 5);
      // Just after the '#' edge. The FSM is in CHECK.
      checks++; if (open !== 1'b0) $display("FAIL open_early0: got %b want 0", open); else passes++;
      @(negedge clk);
      checks++; if (open !== 1'b0) $display("FAIL open_early1: got %b want 0", open); else passes++;
      @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL open_latency: got %b want 1", open); else passes++;
      while (open && n < 2000) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n != 500) $display("FAIL open_length: got %0d cycles want 500", n); else passes++;
      checks++; if (tries !== 3'd0) $display("FAIL open_tries: got %0d want 0", tries); else passes++;
      checks++; if (err_total != e0) $display("FAIL open_err: got %0d pulses want 0", err_total - e0); else passes++;
      ok = 1'b1;
      checks++; if (!ok) $display("FAIL open_dummy: got 0 want 1"); else passes++;
   endtask

   task automatic test_open_reload();
      int n = 0;
      enter(32'h1234B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL reload_open: got %b want 1", open); else passes++;
      repeat (99) @(negedge clk);
      // A '#' while open restarts the full 500-cycle hold from its edge. The
      // falling edge right after it is still within the old hold, so 501
      // high samples remain.
      press(4'hB);
      while (open && n < 2000) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n != 501) $display("FAIL reload_length: got %0d want 501", n); else passes++;
   endtask

   task automatic test_lockout();
      int e0, l0, n;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         e0 = err_total;
         enter(32'h1235B, 5);
         if (i < 2) begin
            repeat (3) @(negedge clk);
            checks++; if (err_total != e0 + 1) $display("FAIL bad_err%0d: got %0d pulses want 1", i, err_total - e0); else passes++;
            checks++; if (tries !== 3'(i + 1)) $display("FAIL bad_tries%0d: got %0d want %0d", i, tries, i + 1); else passes++;
            checks++; if (lock !== 1'b0) $display("FAIL bad_lock%0d: got %b want 0", i, lock); else passes++;
         end else begin
            repeat (2) @(negedge clk);
            checks++; if (lock !== 1'b1) $display("FAIL lock_rise: got %b want 1", lock); else passes++;
            checks++; if (tries !== 3'd3) $display("FAIL lock_tries: got %0d want 3", tries); else passes++;
            checks++; if (err_total != e0 + 1) $display("FAIL lock_err: got %0d pulses want 1", err_total - e0); else passes++;
         end
      end
      l0 = lock_total;
      // The correct code during lockout has no effect.
      enter(32'h1234B, 5);
      repeat (3) @(negedge clk);
      checks++; if (open !== 1'b0) $display("FAIL lock_ignore_open: got %b want 0", open); else passes++;
      checks++; if (lock !== 1'b1) $display("FAIL lock_ignore_lock: got %b want 1", lock); else passes++;
      e0 = err_total;
      n = 0;
      while (lock && n < 3000) begin
         n++;
         @(negedge clk);
      end
      checks++; if (lock !== 1'b0) $display("FAIL lock_end: got %b want 0", lock); else passes++;
      checks++; if (lock_total - l0 != 1000) $display("FAIL lock_length: got %0d want 1000", lock_total - l0); else passes++;
      checks++; if (tries !== 3'd0) $display("FAIL lock_tries_clear: got %0d want 0", tries); else passes++;
      checks++; if (err_total != e0) $display("FAIL lock_no_err: got %0d pulses want 0", err_total - e0); else passes++;
      enter(32'h1234B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL post_lock_open: got %b want 1", open); else passes++;
      wait_open_low(ok);
      checks++; if (!ok) $display("FAIL post_lock_close: open still %b want 0", open); else passes++;
   endtask

   task automatic test_change_pw();
      int e0 = err_total;
      bit ok;
      press(4'hA);
      @(negedge clk);
      checks++; if (save_light !== 1'b1) $display("FAIL chg_save_old: got %b want 1", save_light); else passes++;
      enter(32'h1234B, 5);
      enter(32'h9876B, 5);
      @(negedge clk);
      checks++; if (save_light !== 1'b1) $display("FAIL chg_save_conf: got %b want 1", save_light); else passes++;
      enter(32'h9876B, 5);
      repeat (3) @(negedge clk);
      checks++; if (save_light !== 1'b0) $display("FAIL chg_save_done: got %b want 0", save_light); else passes++;
      checks++; if (err_total != e0) $display("FAIL chg_err: got %0d pulses want 0", err_total - e0); else passes++;
      enter(32'h9876B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL chg_new_open: got %b want 1", open); else passes++;
      wait_open_low(ok);
      e0 = err_total;
      enter(32'h1234B, 5);
      repeat (3) @(negedge clk);
      checks++; if (err_total != e0 + 1) $display("FAIL chg_old_err: got %0d pulses want 1", err_total - e0); else passes++;
      checks++; if (open !== 1'b0) $display("FAIL chg_old_open: got %b want 0", open); else passes++;
      checks++; if (tries !== 3'd1) $display("FAIL chg_old_tries: got %0d want 1", tries); else passes++;
   endtask

   task automatic test_change_mismatch();
      int e0 = err_total;
      bit ok;
      press(4'hA);
      enter(32'h1234B, 5);
      enter(32'h9876B, 5);
      enter(32'h9877B, 5);
      repeat (3) @(negedge clk);
      checks++; if (err_total != e0 + 1) $display("FAIL conf_err: got %0d pulses want 1", err_total - e0); else passes++;
      checks++; if (save_light !== 1'b0) $display("FAIL conf_save: got %b want 0", save_light); else passes++;
      checks++; if (tries !== 3'd0) $display("FAIL conf_tries: got %0d want 0", tries); else passes++;
      enter(32'h1234B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL conf_pw_kept: got %b want 1", open); else passes++;
      wait_open_low(ok);
   endtask

   task automatic test_overflow();
      int e0 = err_total;
      enter(32'h12345B, 6);
      repeat (3) @(negedge clk);
      checks++; if (err_total != e0 + 1) $display("FAIL ovf_err: got %0d pulses want 1", err_total - e0); else passes++;
      checks++; if (tries !== 3'd1) $display("FAIL ovf_tries: got %0d want 1", tries); else passes++;
      checks++; if (open !== 1'b0) $display("FAIL ovf_open: got %b want 0", open); else passes++;
   endtask

   task automatic test_short();
      int e0 = err_total;
      enter(32'h123B, 4);
      repeat (3) @(negedge clk);
      checks++; if (err_total != e0 + 1) $display("FAIL short_err: got %0d pulses want 1", err_total - e0); else passes++;
      checks++; if (tries !== 3'd2) $display("FAIL short_tries: got %0d want 2", tries); else passes++;
   endtask

   task automatic test_cancel();
      int e0 = err_total;
      bit ok;
      enter(32'h12A, 3);
      press(4'hB);
      repeat (3) @(negedge clk);
      checks++; if (err_total != e0) $display("FAIL cancel_err: got %0d pulses want 0", err_total - e0); else passes++;
      checks++; if (tries !== 3'd2) $display("FAIL cancel_tries: got %0d want 2", tries); else passes++;
      checks++; if (open !== 1'b0) $display("FAIL cancel_open: got %b want 0", open); else passes++;
      enter(32'h1234B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL cancel_then_open: got %b want 1", open); else passes++;
      checks++; if (tries !== 3'd0) $display("FAIL cancel_tries_clr: got %0d want 0", tries); else passes++;
      wait_open_low(ok);
   endtask

   task automatic test_partial_persist();
      bit ok;
      press(4'h1);
      repeat (100) @(negedge clk);
      enter(32'h234B, 4);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL slow_entry_open: got %b want 1", open); else passes++;
      wait_open_low(ok);
   endtask

   task automatic test_reset_in_sav_conf();
      int e0;
      bit ok;
      press(4'hA);
      enter(32'h1234B, 5);
      enter(32'h9876B, 5);
      enter(32'h98, 2);
      checks++; if (save_light !== 1'b1) $display("FAIL rst_conf_save: got %b want 1", save_light); else passes++;
      apply_reset();
      checks++; if (save_light !== 1'b0) $display("FAIL rst_conf_save_clr: got %b want 0", save_light); else passes++;
      e0 = err_total;
      enter(32'h9876B, 5);
      repeat (3) @(negedge clk);
      checks++; if (err_total != e0 + 1) $display("FAIL rst_conf_new_rejected: got %0d pulses want 1", err_total - e0); else passes++;
      enter(32'h1234B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL rst_conf_pw_kept: got %b want 1", open); else passes++;
      wait_open_low(ok);
   endtask

`ifdef LOCK_TIMEOUT_EN
   task automatic test_timeout();
      int e0 = err_total;
      logic [2:0] t0 = tries;
      bit ok;
      press(4'h1);
      repeat (1990) @(negedge clk);
      checks++; if (err_total != e0) $display("FAIL tmo_early: got %0d pulses want 0", err_total - e0); else passes++;
      repeat (20) @(negedge clk);
      checks++; if (err_total != e0 + 1) $display("FAIL tmo_err: got %0d pulses want 1", err_total - e0); else passes++;
      checks++; if (tries !== t0) $display("FAIL tmo_tries: got %0d want %0d", tries, t0); else passes++;
      enter(32'h1234B, 5);
      repeat (2) @(negedge clk);
      checks++; if (open !== 1'b1) $display("FAIL tmo_then_open: got %b want 1", open); else passes++;
      wait_open_low(ok);
   endtask
`endif

   initial begin
      test_reset();
      test_open();
      test_open_reload();
      test_lockout();
      test_change_pw();
      apply_reset();
      test_change_mismatch();
      test_overflow();
      test_short();
      test_cancel();
      test_partial_persist();
      test_reset_in_sav_conf();
`ifdef LOCK_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Keypad-driven sequencer for the combination lock: it consumes one 4-bit key code per `valid` pulse, collects password digits, runs the enter/compare, change-password and lockout flows, and owns the stored password register. It sits between the keypad scanner/debouncer and the lock actuator and indicator LEDs. It replaces ad-hoc per-state decoding with a single registered FSM. Key codes: digits 0–9 = 4'b0000–4'b1001, `*` = 4'b1010, `#` = 4'b1011; 4'b1100–4'b1111 are ignored.

## Interface
- CODE_LEN, 4: digits per password (1–8).
- MAX_TRIES, 3: consecutive failed compares before lockout (1–7).
- OPEN_CYCLES, 500: cycles `open` is held after a match.
- LOCKOUT_CYCLES, 1000: cycles `lock` is held.
- DEFAULT_PW, 16'h1234: password after reset, one nibble per digit, first digit in the MS nibble.
- IDLE_TIMEOUT, 2000: inactivity limit in cycles; only used with LOCK_TIMEOUT_EN.

- clk  in  1  system clock.
- reset_1  in  1  synchronous, active-high reset.
- code  in  4  key code, valid only when `valid`=1.
- valid  in  1  one-cycle strobe; one code consumed per high cycle.
- open  out  1  lock released.
- lock  out  1  lockout active.
- save_light  out  1  change-password flow active.
- err  out  1  one-cycle pulse on a failed or aborted entry.
- tries  out  3  current consecutive-failure count.

## Operation
- States: IDLE, ENTER, CHECK, OPEN, SAV_OLD, SAV_NEW, SAV_CONF, LOCKOUT.
- Entry buffer: shift register of CODE_LEN nibbles, digit count `cnt`, and overflow flag `ovf`. `ovf` is set on any digit received when `cnt`==CODE_LEN; extra digits are not stored. The buffer is cleared on entering ENTER, SAV_OLD, SAV_NEW and SAV_CONF.
- IDLE: a digit loads the buffer with `cnt`=1 and moves to ENTER. `*` moves to SAV_OLD. `#` is ignored.
- ENTER: a digit is stored. `#` moves to CHECK. `*` cancels to IDLE, with no `err` and no try counted.
- CHECK (1 cycle): a match means buffer==pw, `cnt`==CODE_LEN and `ovf`=0.
  - Match: go to OPEN and clear `tries`.
  - Mismatch: pulse `err` and increment `tries`. If `tries` reaches MAX_TRIES go to LOCKOUT, otherwise go to IDLE.
- OPEN: `open`=1 while the timer counts OPEN_CYCLES, then return to IDLE. A `#` in OPEN reloads the timer. Other keys are ignored.
- SAV_OLD: collect digits, then `#` compares against pw.
  - Pass: go to SAV_NEW and clear `tries`.
  - Fail: same rules as a CHECK mismatch.
- SAV_NEW: collect exactly CODE_LEN digits. `#` latches the buffer into `new_pw` and moves to SAV_CONF. A wrong length pulses `err` and returns to IDLE.
- SAV_CONF: collect digits, then `#`.
  - Buffer==`new_pw` with correct length: pw <= `new_pw`, go to IDLE.
  - Otherwise: pulse `err`, go to IDLE, pw unchanged.
- `*` in any SAV_* state aborts to IDLE, with no `err` and pw unchanged.
- LOCKOUT: all input is ignored. After LOCKOUT_CYCLES, clear `tries` and go to IDLE.
- `save_light`=1 in SAV_OLD, SAV_NEW and SAV_CONF. `lock`=1 only in LOCKOUT. `open`=1 only in OPEN.
- Failures in CHECK and SAV_OLD share the `tries` counter. SAV_NEW/SAV_CONF mismatches do not count as tries.

## Timing
- Reset values: state IDLE; pw=DEFAULT_PW; `open`, `lock`, `save_light`, `err` = 0; `tries`=0; all timers 0.
- Reset mid-operation aborts any flow. A password change is committed only in the SAV_CONF success cycle, so pw is either fully old or fully new.
- All outputs are registered and reflect the state one cycle after the edge that transitions into it.
- `valid` is sampled on the rising edge of `clk`.
- `#` latency: `#` → CHECK on the next edge → OPEN/IDLE/LOCKOUT one edge later. `open` rises 2 cycles after the `#` edge.
- `valid` during CHECK is dropped; the keypad is guaranteed to pace strobes at least 2 cycles apart.
- Timers are down-counters sized by $clog2 of their parameter. OPEN lasts exactly OPEN_CYCLES cycles and LOCKOUT exactly LOCKOUT_CYCLES cycles.

## Configuration
- `LOCK_TIMEOUT_EN` defined:
  - In ENTER and SAV_*, an inactivity counter reloads on every `valid`.
  - When IDLE_TIMEOUT cycles elapse with no `valid`: pulse `err`, go to IDLE, clear the buffer, do not increment `tries`.
- Undefined: the counter logic is absent and partial entries persist indefinitely.

## Test plan
- Reset, then keys 1,2,3,4,# → `open`=1 two cycles after `#`, held 500 cycles, `tries`=0.
- Keys 1,2,3,5,# three times → `err` pulses with `tries`=1,2; third failure gives `lock`=1 for 1000 cycles while key input is ignored; then IDLE with `tries`=0.
- Keys *,1,2,3,4,#,9,8,7,6,#,9,8,7,6,# → `save_light`=1 during the flow; afterwards 9,8,7,6,# opens and 1,2,3,4,# gives `err`.
- Change flow with confirmation 9,8,7,7 → `err`; pw stays 1234.
- Keys 1,2,3,4,5,# → `ovf` set, `err`, `tries`=1. Keys 1,2,* → cancel, no `err`. Reset asserted in SAV_CONF → IDLE, pw=1234.
- With LOCK_TIMEOUT_EN: key 1, then 2000 idle cycles → `err`, IDLE, `tries` unchanged.
